// File: rtl/demux4_router.sv
// demux4_router: routes tagged input words into four small FIFOs,
// each draining to its own valid/ready port with a delivered-word counter.
module demux4_router #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    output logic [CNT_W-1:0]  count_0,
    output logic [CNT_W-1:0]  count_1,
    output logic [CNT_W-1:0]  count_2,
    output logic [CNT_W-1:0]  count_3,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]                full;
    logic [3:0]                push;
    logic [3:0]                pop;
    logic [3:0][DATA_W-1:0]    head;
    logic [3:0][CNT_W-1:0]     cnt;

    // Readiness depends only on the selected channel, so a full channel never blocks the others.
    assign in_ready = !full[in_sel];
    assign busy     = |out_valid;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [AW:0]       occ;

        assign full[k]      = occ == (AW+1)'(DEPTH);
        assign out_valid[k] = occ != '0;
        assign push[k]      = in_valid && in_ready && in_sel == 2'(k);
        assign pop[k]       = out_valid[k] && out_ready[k];
        assign head[k]      = mem[rd_ptr];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                cnt[k] <= '0;
            end else begin
                if (push[k]) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    cnt[k] <= cnt[k] + 1'b1;
                end
                occ <= occ + {{AW{1'b0}}, push[k]} - {{AW{1'b0}}, pop[k]};
            end
        end
    end

    assign out_data_0 = head[0];
    assign out_data_1 = head[1];
    assign out_data_2 = head[2];
    assign out_data_3 = head[3];
    assign count_0    = cnt[0];
    assign count_1    = cnt[1];
    assign count_2    = cnt[2];
    assign count_3    = cnt[3];
endmodule

// File: doc/demux4_router.md
# demux4_router

Four-way stream demultiplexer: the distribution side of the design's 4:1 data selector. It accepts 4-bit words on a single valid/ready input port, each tagged with a 2-bit destination, and steers each word into a small per-channel FIFO. Each FIFO drains to its own valid/ready output port. Four consumers can therefore be fed from one producer without stalling on each other, up to the buffer depth. It sits between the shared datapath output and the four per-channel consumers.

## Interface
- DATA_W, 4, width of each data word
- DEPTH, 2, entries per channel FIFO; power of two, >= 2
- CNT_W, 8, width of per-channel delivered-word counters
- clk  input  1  rising-edge clock; the only clock
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  word will be accepted this cycle if in_valid
- in_data  input  DATA_W  word to route
- in_sel  input  2  destination channel 0..3; sampled with in_data
- out_valid  output  4  bit k: channel k FIFO non-empty
- out_ready  input  4  bit k: consumer k takes the head word
- out_data_0..out_data_3  output  DATA_W each  head word of channel k FIFO
- count_0..count_3  output  CNT_W each  words delivered on channel k, modulo 2^CNT_W
- busy  output  1  any channel FIFO non-empty

## Operation
- Input accept (push): the cycle with in_valid & in_ready. The word goes to the tail of FIFO[in_sel].
- in_ready = !full[in_sel]. It depends combinationally on in_sel only, never on out_ready. A full channel does not accept a word even if it pops in the same cycle.
- The input never stalls on a non-full channel because another channel is full. There is no head-of-line blocking beyond the single input word.
- Output pop: on channel k, the cycle with out_valid[k] & out_ready[k]. The head is removed and count_k increments by 1, wrapping from 2^CNT_W-1 to 0.
- out_data_k is driven from storage (register) at the read pointer. It is stable while out_valid[k] is high and the head is not popped.
- Each FIFO has read/write pointers of log2(DEPTH) bits and an occupancy counter of log2(DEPTH)+1 bits.
  - full = (occ == DEPTH); empty = (occ == 0).
  - Pointers wrap modulo DEPTH.
- Push and pop on the same channel in the same cycle (non-empty, non-full): occupancy is unchanged and both pointers advance.
- Push to channel j and pops on any other channels in the same cycle: all are processed independently.
- Order: strict FIFO per channel. No ordering is defined between channels.
- in_sel or in_data changing while in_valid is low has no effect.
- busy = |out_valid.

## Timing
- Reset (resetn low, asynchronous assert):
  - all FIFOs empty and pointers 0
  - out_valid = 0, out_data_k = 0, count_k = 0, busy = 0
  - in_ready = 1
- Release of resetn is synchronous to clk. The first push is possible on the first rising edge after release.
- Latency: a word pushed on edge N appears on out_valid/out_data of its channel immediately after edge N (one cycle from acceptance to availability). It can be popped at edge N+1 at the earliest.
- Occupancy, pointers and count_k update only on the rising edge.
- Reset asserted mid-operation: all buffered words are discarded and counters are cleared immediately, regardless of clk. Nothing is delivered after reset.
- Full boundary: after DEPTH pushes to channel k with no pops, in_ready = 0 whenever in_sel == k. After one pop on edge M, in_ready for k returns to 1 after edge M.
- Empty boundary: the pop of the last word on edge M sets out_valid[k] = 0 after edge M, unless a push to k happens on the same edge.

## Test plan
- Reset then idle: hold resetn = 0 for 3 cycles with random inputs -> out_valid = 4'b0000, all count_k = 0, busy = 0, in_ready = 1. Release and hold out_ready = 4'b0000 -> no change.
- Routing and order: with out_ready = 0, push A,B to ch2 and 5 to ch0 -> out_valid = 4'b0101, out_data_2 = A. Then set out_ready = 4'b0100 for 2 cycles -> ch2 delivers A then B, count_2 = 2, out_valid = 4'b0001.
- Full/backpressure: with out_ready = 0, push 1,2 to ch3 -> with in_sel = 3, in_ready = 0 and a third word is not accepted. With in_sel = 1, in_ready = 1 and the push lands in ch1 -> out_valid = 4'b1010.
- Simultaneous push/pop at occupancy 1 on ch1: continuous stream 0..9 with out_ready[1] = 1 -> ch1 delivers 0..9 in order at one word per cycle after the first, occupancy stays 1, in_ready is never 0, count_1 = 10.
- Counter wrap (CNT_W = 8): deliver 257 words on ch0 -> count_0 = 1, other counters 0.
- Reset mid-operation: fill ch0 and ch3 to full, assert resetn low asynchronously mid-cycle -> out_valid = 0 and count_k = 0 immediately. After release, the first word pushed to ch0 is the first word delivered on ch0.
